exec_unit: RTL and testbench

Parametrised execute stage for the out-of-order core: accepts one issued micro-op per handshake, selects ALU operands from registers, PC, immediate or constants, and produces a tagged result through a registered valid/ready output. Single-cycle ALU ops complete in one cycle. Multiply ops run on an iterative shift-add multiplier. A flush input kills in-flight work. Sits between issue/register-read and the writeback/ROB completion port.

---
 rtl/exec_unit_pkg.sv | 42 ++++
 rtl/alu.sv | 44 ++++
 rtl/exec_mul_iter.sv | 102 ++++++++++
 rtl/exec_unit.sv | 120 ++++++++++++
 tb/tb_exec_unit.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/exec_unit_pkg.sv
// Shared encodings for the execute stage: operand selects, multiply ops and multiplier states.
package exec_unit_pkg;

    typedef enum logic [1:0] {
        OP1_RS1     = 2'b00,
        OP1_PC      = 2'b01,
        OP1_ZERO    = 2'b10,
        OP1_RS1_ALT = 2'b11
    } opsel1_e;

    typedef enum logic [1:0] {
        OP2_RS2     = 2'b00,
        OP2_IMM     = 2'b01,
        OP2_FOUR    = 2'b10,
        OP2_RS2_ALT = 2'b11
    } opsel2_e;

    typedef enum logic [1:0] {
        MUL_LO  = 2'b00,
        MUL_HSS = 2'b01,
        MUL_HSU = 2'b10,
        MUL_HUU = 2'b11
    } mul_op_e;

    typedef enum logic [1:0] {
        MS_IDLE = 2'b00,
        MS_RUN  = 2'b01,
        MS_DONE = 2'b10
    } mul_state_e;

    localparam int CONST_FOUR = 4;

    // MUL only keeps the low half, which is identical for any signedness, so it runs unsigned.
    function automatic logic mul_a_signed(input logic [1:0] op);
        return (op == MUL_HSS) || (op == MUL_HSU);
    endfunction

    function automatic logic mul_b_signed(input logic [1:0] op);
        return op == MUL_HSS;
    endfunction

endpackage

// File: rtl/alu.sv
// Single-cycle integer ALU shared by the execute stages.
module alu #(
    parameter int WIDTH = 32
) (
    input  logic [3:0]       func,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result
);

    localparam int SH_W = $clog2(WIDTH);

    localparam logic [3:0] F_ADD  = 4'd0;
    localparam logic [3:0] F_SUB  = 4'd1;
    localparam logic [3:0] F_SLL  = 4'd2;
    localparam logic [3:0] F_SLT  = 4'd3;
    localparam logic [3:0] F_SLTU = 4'd4;
    localparam logic [3:0] F_XOR  = 4'd5;
    localparam logic [3:0] F_SRL  = 4'd6;
    localparam logic [3:0] F_SRA  = 4'd7;
    localparam logic [3:0] F_OR   = 4'd8;
    localparam logic [3:0] F_AND  = 4'd9;

    logic [SH_W-1:0] shamt;
    assign shamt = b[SH_W-1:0];

    always_comb begin
        result = '0;
        case (func)
            F_ADD:   result = a + b;
            F_SUB:   result = a - b;
            F_SLL:   result = a << shamt;
            F_SLT:   result = WIDTH'($signed(a) < $signed(b));
            F_SLTU:  result = WIDTH'(a < b);
            F_XOR:   result = a ^ b;
            F_SRL:   result = a >> shamt;
            F_SRA:   result = $signed(a) >>> shamt;
            F_OR:    result = a | b;
            F_AND:   result = a & b;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/exec_mul_iter.sv
// Iterative shift-add multiplier: one multiplier bit per cycle on operand magnitudes, sign fixed at the end.
//   state   | meaning
//   MS_IDLE | waiting for start
//   MS_RUN  | WORD shift-add steps, cnt_q counts down to terminal count 1
//   MS_DONE | result valid until taken
module exec_mul_iter
    import exec_unit_pkg::*;
#(
    parameter int WORD = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    input  logic            flush,
    input  logic            taken,
    input  logic [1:0]      op,
    input  logic [WORD-1:0] a,
    input  logic [WORD-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [WORD-1:0] result
);

    localparam int CNT_W = $clog2(WORD) + 1;

    mul_state_e          state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [2*WORD-1:0]   acc_q;
    logic [2*WORD-1:0]   mcand_q;
    logic [WORD-1:0]     mplier_q;
    logic                neg_q;
    logic [1:0]          op_q;

    logic                a_neg, b_neg;
    logic [WORD-1:0]     a_mag, b_mag;
    logic [2*WORD-1:0]   prod;

    assign a_neg = mul_a_signed(op) & a[WORD-1];
    assign b_neg = mul_b_signed(op) & b[WORD-1];
    assign a_mag = a_neg ? -a : a;
    assign b_mag = b_neg ? -b : b;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= MS_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            neg_q    <= 1'b0;
            op_q     <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else if (flush) begin
            state_q <= MS_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (state_q)
                MS_IDLE: begin
                    if (start) begin
                        state_q  <= MS_RUN;
                        cnt_q    <= CNT_W'(WORD);
                        acc_q    <= '0;
                        mcand_q  <= {{WORD{1'b0}}, a_mag};
                        mplier_q <= b_mag;
                        neg_q    <= a_neg ^ b_neg;
                        op_q     <= op;
                        busy     <= 1'b1;
                    end
                end
                MS_RUN: begin
                    if (mplier_q[0])
                        acc_q <= acc_q + mcand_q;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_q <= MS_DONE;
                        done    <= 1'b1;
                    end
                end
                MS_DONE: begin
                    if (taken) begin
                        state_q <= MS_IDLE;
                        busy    <= 1'b0;
                        done    <= 1'b0;
                    end
                end
                default: begin
                    state_q <= MS_IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

    assign prod   = neg_q ? -acc_q : acc_q;
    assign result = (op_q == MUL_LO) ? prod[WORD-1:0] : prod[2*WORD-1:WORD];

endmodule

// File: rtl/exec_unit.sv
// Execute stage: operand select, single-cycle ALU, iterative multiplier and a registered tagged result.
module exec_unit
    import exec_unit_pkg::*;
#(
    parameter int WORD     = 32,
    parameter int ADDR_LEN = 32,
    parameter int TAG_W    = 6
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [TAG_W-1:0]    in_tag,
    input  logic [1:0]          opsel1,
    input  logic [1:0]          opsel2,
    input  logic [3:0]          alu_func,
    input  logic                is_mul,
    input  logic [1:0]          mul_op,
    input  logic [WORD-1:0]     rs1_value,
    input  logic [WORD-1:0]     rs2_value,
    input  logic [WORD-1:0]     imm,
    input  logic [ADDR_LEN-1:0] pc_i,
    input  logic                flush,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [TAG_W-1:0]    out_tag,
    output logic [ADDR_LEN-1:0] out_pc,
    output logic [WORD-1:0]     out_result
);

    logic [WORD-1:0]     pc_ext, op1, op2, alu_result, mul_result;
    logic                mul_busy, mul_done, accept, alu_take, mul_start, mul_take;
    logic [TAG_W-1:0]    mul_tag_q;
    logic [ADDR_LEN-1:0] mul_pc_q;

    always_comb begin
        pc_ext = '0;
        pc_ext[ADDR_LEN-1:0] = pc_i;
    end

    always_comb begin
        op1 = rs1_value;
        case (opsel1)
            OP1_PC:   op1 = pc_ext;
            OP1_ZERO: op1 = '0;
            default:  op1 = rs1_value;
        endcase
    end

    always_comb begin
        op2 = rs2_value;
        case (opsel2)
            OP2_IMM:  op2 = imm;
            OP2_FOUR: op2 = WORD'(CONST_FOUR);
            default:  op2 = rs2_value;
        endcase
    end

    assign in_ready  = !mul_busy && (!out_valid || out_ready);
    assign accept    = in_valid && in_ready && !flush;
    assign alu_take  = accept && !is_mul;
    assign mul_start = accept && is_mul;
    assign mul_take  = mul_done && (!out_valid || out_ready) && !flush;

    alu #(.WIDTH(WORD)) u_alu (
        .func   (alu_func),
        .a      (op1),
        .b      (op2),
        .result (alu_result)
    );

    exec_mul_iter #(.WORD(WORD)) u_mul (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (mul_start),
        .flush   (flush),
        .taken   (mul_take),
        .op      (mul_op),
        .a       (op1),
        .b       (op2),
        .busy    (mul_busy),
        .done    (mul_done),
        .result  (mul_result)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mul_tag_q <= '0;
            mul_pc_q  <= '0;
        end else if (mul_start) begin
            mul_tag_q <= in_tag;
            mul_pc_q  <= pc_i;
        end
    end

    // Accept and multiplier hand-off are mutually exclusive: in_ready is low while the multiplier is busy.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid  <= 1'b0;
            out_tag    <= '0;
            out_pc     <= '0;
            out_result <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (alu_take) begin
            out_valid  <= 1'b1;
            out_tag    <= in_tag;
            out_pc     <= pc_i;
            out_result <= alu_result;
        end else if (mul_take) begin
            out_valid  <= 1'b1;
            out_tag    <= mul_tag_q;
            out_pc     <= mul_pc_q;
            out_result <= mul_result;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_exec_unit.sv
// Directed bench for exec_unit: ALU path, multiply variants, backpressure, flush and async reset.
module tb_exec_unit;

    localparam int WORD     = 32;
    localparam int ADDR_LEN = 32;
    localparam int TAG_W    = 6;

    logic                clk;
    logic                reset_n;
    logic                in_valid;
    logic                in_ready;
    logic [TAG_W-1:0]    in_tag;
    logic [1:0]          opsel1;
    logic [1:0]          opsel2;
    logic [3:0]          alu_func;
    logic                is_mul;
    logic [1:0]          mul_op;
    logic [WORD-1:0]     rs1_value;
    logic [WORD-1:0]     rs2_value;
    logic [WORD-1:0]     imm;
    logic [ADDR_LEN-1:0] pc_i;
    logic                flush;
    logic                out_valid;
    logic                out_ready;
    logic [TAG_W-1:0]    out_tag;
    logic [ADDR_LEN-1:0] out_pc;
    logic [WORD-1:0]     out_result;

    int n_pass  = 0;
    int n_total = 0;

    exec_unit #(.WORD(WORD), .ADDR_LEN(ADDR_LEN), .TAG_W(TAG_W)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_tag     (in_tag),
        .opsel1     (opsel1),
        .opsel2     (opsel2),
        .alu_func   (alu_func),
        .is_mul     (is_mul),
        .mul_op     (mul_op),
        .rs1_value  (rs1_value),
        .rs2_value  (rs2_value),
        .imm        (imm),
        .pc_i       (pc_i),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_tag    (out_tag),
        .out_pc     (out_pc),
        .out_result (out_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic set_op(input logic [TAG_W-1:0] tag, input logic mul, input logic [1:0] mop,
                          input logic [3:0] func, input logic [1:0] s1, input logic [1:0] s2,
                          input logic [WORD-1:0] a, input logic [WORD-1:0] b,
                          input logic [WORD-1:0] im, input logic [ADDR_LEN-1:0] pc);
        in_valid  = 1'b1;
        in_tag    = tag;
        is_mul    = mul;
        mul_op    = mop;
        alu_func  = func;
        opsel1    = s1;
        opsel2    = s2;
        rs1_value = a;
        rs2_value = b;
        imm       = im;
        pc_i      = pc;
    endtask

    task automatic run_mul(input string name, input logic [1:0] mop, input logic [WORD-1:0] a,
                           input logic [WORD-1:0] b, input logic [WORD-1:0] exp,
                           input logic [TAG_W-1:0] tag);
        int   lat;
        logic rdy_seen;
        @(negedge clk);
        set_op(tag, 1'b1, mop, 4'd0, 2'b00, 2'b00, a, b, '0, 32'h3000);
        @(negedge clk);
        in_valid = 1'b0;
        lat      = 0;
        rdy_seen = 1'b0;
        while (!out_valid && lat < 100) begin
            if (in_ready) rdy_seen = 1'b1;
            @(negedge clk);
            lat++;
        end
        check({name, "_lat"}, 64'(lat), 64'd33);
        check({name, "_res"}, 64'(out_result), 64'(exp));
        check({name, "_tag"}, 64'(out_tag), 64'(tag));
        check({name, "_rdy_low"}, 64'(rdy_seen), 64'd0);
    endtask

    initial begin
        int   seen;
        logic [TAG_W-1:0] held_tag;
        logic [WORD-1:0]  held_res;

        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_tag    = '0;
        opsel1    = '0;
        opsel2    = '0;
        alu_func  = '0;
        is_mul    = 1'b0;
        mul_op    = '0;
        rs1_value = '0;
        rs2_value = '0;
        imm       = '0;
        pc_i      = '0;
        flush     = 1'b0;
        out_ready = 1'b1;

        repeat (2) @(negedge clk);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_ready", 64'(in_ready), 64'd1);
        check("rst_result", 64'(out_result), 64'd0);
        reset_n = 1'b1;

        // ADD pc + 4
        @(negedge clk);
        set_op(6'd5, 1'b0, 2'b00, 4'd0, 2'b01, 2'b10, 32'hDEAD, 32'hBEEF, '0, 32'h1000);
        @(negedge clk);
        in_valid = 1'b0;
        check("add_valid", 64'(out_valid), 64'd1);
        check("add_res", 64'(out_result), 64'h1004);
        check("add_tag", 64'(out_tag), 64'd5);
        check("add_pc", 64'(out_pc), 64'h1000);

        run_mul("mulhu",  2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 6'd20);
        run_mul("mulh",   2'b01, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 6'd21);
        run_mul("mul",    2'b00, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 6'd22);
        run_mul("mulhsu", 2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 6'd23);

        // Backpressure: SUB 10-3 held, XOR with imm pending
        @(negedge clk);
        out_ready = 1'b0;
        set_op(6'd7, 1'b0, 2'b00, 4'd1, 2'b00, 2'b00, 32'd10, 32'd3, '0, 32'h2000);
        @(negedge clk);
        set_op(6'd8, 1'b0, 2'b00, 4'd5, 2'b00, 2'b01, 32'h0000F0F0, '0, 32'h00000FF0, 32'h2004);
        for (int i = 0; i < 4; i++) begin
            check("bp_tag", 64'(out_tag), 64'd7);
            check("bp_res", 64'(out_result), 64'd7);
            check("bp_ready", 64'(in_ready), 64'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check("handoff_valid", 64'(out_valid), 64'd1);
        check("handoff_tag", 64'(out_tag), 64'd8);
        check("handoff_res", 64'(out_result), 64'h0000FF00);

        // Flush at RUN cycle 7
        @(negedge clk);
        set_op(6'd9, 1'b1, 2'b11, 4'd0, 2'b00, 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, '0, 32'h4000);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (7) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_ready", 64'(in_ready), 64'd1);
        check("flush_valid", 64'(out_valid), 64'd0);
        set_op(6'd10, 1'b0, 2'b00, 4'd1, 2'b00, 2'b01, 32'd100, '0, 32'd1, 32'h4004);
        @(negedge clk);
        in_valid = 1'b0;
        check("post_flush_valid", 64'(out_valid), 64'd1);
        check("post_flush_tag", 64'(out_tag), 64'd10);
        check("post_flush_res", 64'(out_result), 64'd99);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid && out_tag == 6'd9) seen++;
        end
        check("flush_no_result", 64'(seen), 64'd0);

        // flush with out_ready drops the held result and blocks the pending accept
        @(negedge clk);
        out_ready = 1'b0;
        set_op(6'd11, 1'b0, 2'b00, 4'd0, 2'b00, 2'b00, 32'd1, 32'd2, '0, 32'h5000);
        @(negedge clk);
        check("drop_pre_valid", 64'(out_valid), 64'd1);
        set_op(6'd12, 1'b0, 2'b00, 4'd0, 2'b00, 2'b00, 32'd5, 32'd6, '0, 32'h5004);
        flush     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        check("drop_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        check("drop_no_accept", 64'(out_valid), 64'd0);

        // Async reset at RUN cycle 10
        @(negedge clk);
        set_op(6'd13, 1'b1, 2'b11, 4'd0, 2'b00, 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, '0, 32'h6000);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (10) @(negedge clk);
        held_tag = out_tag;
        held_res = out_result;
        #1 reset_n = 1'b0;
        #1;
        check("arst_valid", 64'(out_valid), 64'd0);
        check("arst_tag", 64'(out_tag), 64'd0);
        check("arst_pc", 64'(out_pc), 64'd0);
        check("arst_result", 64'(out_result), 64'd0);
        #1 reset_n = 1'b1;
        @(negedge clk);
        check("arst_ready", 64'(in_ready), 64'd1);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("arst_no_stale", 64'(seen), 64'd0);
        if (held_tag == 6'd0 && held_res == '0) $display("note: reset checks ran on an already-zero register");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
